// File: rtl/rrv64_core_vec_param_pkg.sv
// Shared vector-core parameters and types, including the write-back queue entry layout.
package rrv64_core_vec_param_pkg;

  localparam int VREG_ADDR_WIDTH = 5;
  localparam int VFULEN          = 64;
  localparam int VRF_WB_DEPTH    = 8;

  typedef struct packed {
    logic [VREG_ADDR_WIDTH-1:0] addr;
    logic [VFULEN-1:0]          data;
    logic                       done;
  } vrf_wb_entry_t;

endpackage

// File: rtl/vrf_wb_retire_ctrl.sv
// Combinational retire decision for the two oldest write-back entries: requests, pop count, done-set.
module vrf_wb_retire_ctrl #(
  parameter int CNT_WIDTH  = 4,
  parameter int ADDR_WIDTH = 5
) (
  input  logic [CNT_WIDTH-1:0]  count,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic                  done0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic                  done1,
  input  logic                  wr0_conflict,
  input  logic                  wr1_conflict,
  output logic                  wr0_vld,
  output logic                  wr1_vld,
  output logic [1:0]            pop_cnt,
  output logic                  set_done1
);

  logic occ0, occ1, grant0, grant1, pop0, pop1;

  always_comb begin
    occ0    = (count >= CNT_WIDTH'(1));
    occ1    = (count >= CNT_WIDTH'(2));
    wr0_vld = occ0 & ~done0;
    // Same-register writes must land in order, so slot 1 waits behind a matching head.
    wr1_vld = occ1 & ~done1 & (addr1 != addr0);
    grant0  = wr0_vld & ~wr0_conflict;
    grant1  = wr1_vld & ~wr1_conflict;
    pop0    = occ0 & (grant0 | done0);
    pop1    = pop0 & occ1 & (grant1 | done1);
    pop_cnt = {1'b0, pop0} + {1'b0, pop1};
    // Slot 1 wrote around a stalled head; remember it so it is not written twice.
    set_done1 = grant1 & ~pop0;
  end

endmodule

// File: rtl/vrf_wb_queue.sv
// In-order write-back queue feeding two VRF write ports with conflict retry.
// Optional conflict counter port under `VRF_WB_PERF_EN.
module vrf_wb_queue
  import rrv64_core_vec_param_pkg::*;
#(
  parameter int DEPTH      = VRF_WB_DEPTH,
  parameter int ADDR_WIDTH = VREG_ADDR_WIDTH,
  parameter int DATA_WIDTH = VFULEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in0_vld,
  output logic                  in0_rdy,
  input  logic [ADDR_WIDTH-1:0] in0_addr,
  input  logic [DATA_WIDTH-1:0] in0_data,
  input  logic                  in1_vld,
  output logic                  in1_rdy,
  input  logic [ADDR_WIDTH-1:0] in1_addr,
  input  logic [DATA_WIDTH-1:0] in1_data,
  output logic                  wr0_vld,
  input  logic                  wr0_conflict,
  output logic [ADDR_WIDTH-1:0] waddr0,
  output logic [DATA_WIDTH-1:0] wdata0,
  output logic                  wr1_vld,
  input  logic                  wr1_conflict,
  output logic [ADDR_WIDTH-1:0] waddr1,
  output logic [DATA_WIDTH-1:0] wdata1,
`ifdef VRF_WB_PERF_EN
  output logic [31:0]           conflict_cnt,
`endif
  output logic                  empty
);

  localparam int PW = $clog2(DEPTH);

  // Same layout as vrf_wb_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  done;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] head, tail, head_n1, tail_n1, wr1_idx;
  logic [PW:0]   count, count_vis;
  logic          rdy, acc0, acc1, set_done1;
  logic [1:0]    n_acc, pop_cnt;

  always_comb begin
    rdy       = (count <= (PW+1)'(DEPTH - 2));
    acc0      = in0_vld & rdy;
    acc1      = in1_vld & rdy;
    n_acc     = {1'b0, acc0} + {1'b0, acc1};
    head_n1   = head + 1'b1;
    tail_n1   = tail + 1'b1;
    wr1_idx   = acc0 ? tail_n1 : tail;
    // Hiding the count during reset keeps both write ports quiet in that cycle.
    count_vis = rst ? '0 : count;
  end

  assign in0_rdy = rdy;
  assign in1_rdy = rdy;
  assign empty   = (count == '0);
  assign waddr0  = mem[head].addr;
  assign wdata0  = mem[head].data;
  assign waddr1  = mem[head_n1].addr;
  assign wdata1  = mem[head_n1].data;

  vrf_wb_retire_ctrl #(
    .CNT_WIDTH  (PW + 1),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_retire (
    .count        (count_vis),
    .addr0        (mem[head].addr),
    .done0        (mem[head].done),
    .addr1        (mem[head_n1].addr),
    .done1        (mem[head_n1].done),
    .wr0_conflict (wr0_conflict),
    .wr1_conflict (wr1_conflict),
    .wr0_vld      (wr0_vld),
    .wr1_vld      (wr1_vld),
    .pop_cnt      (pop_cnt),
    .set_done1    (set_done1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      // NOTE: only the done bits are reset; addr/data are qualified by count and stay unreset storage.
      for (int i = 0; i < DEPTH; i++) mem[i].done <= 1'b0;
    end else begin
      if (pop_cnt != 2'd0) mem[head].done    <= 1'b0;
      if (pop_cnt == 2'd2) mem[head_n1].done <= 1'b0;
      if (set_done1)       mem[head_n1].done <= 1'b1;
      // Enqueue targets free slots only, so it never collides with the done updates above.
      if (acc0) mem[tail]    <= '{addr: in0_addr, data: in0_data, done: 1'b0};
      if (acc1) mem[wr1_idx] <= '{addr: in1_addr, data: in1_data, done: 1'b0};
      head  <= head + PW'(pop_cnt);
      tail  <= tail + PW'(n_acc);
      count <= count + (PW+1)'(n_acc) - (PW+1)'(pop_cnt);
    end
  end

`ifdef VRF_WB_PERF_EN
  logic [1:0]  conf_inc;
  logic [32:0] conf_sum;

  always_comb begin
    conf_inc = {1'b0, wr0_vld & wr0_conflict} + {1'b0, wr1_vld & wr1_conflict};
    conf_sum = {1'b0, conflict_cnt} + 33'(conf_inc);
  end

  always_ff @(posedge clk) begin
    if (rst)              conflict_cnt <= '0;
    else if (conf_sum[32]) conflict_cnt <= '1;
    else                   conflict_cnt <= conf_sum[31:0];
  end
`endif

endmodule

// File: tb/tb_vrf_wb_queue.sv
// Directed self-checking bench for vrf_wb_queue; checks conflict_cnt when VRF_WB_PERF_EN is defined.
module tb_vrf_wb_queue;
  import rrv64_core_vec_param_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       in0_vld, in1_vld, in0_rdy, in1_rdy;
  logic [VREG_ADDR_WIDTH-1:0] in0_addr, in1_addr, waddr0, waddr1;
  logic [VFULEN-1:0]          in0_data, in1_data, wdata0, wdata1;
  logic                       wr0_vld, wr1_vld, wr0_conflict, wr1_conflict, empty;
`ifdef VRF_WB_PERF_EN
  logic [31:0]                conflict_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vrf_wb_queue dut (
    .clk          (clk),
    .rst          (rst),
    .in0_vld      (in0_vld),
    .in0_rdy      (in0_rdy),
    .in0_addr     (in0_addr),
    .in0_data     (in0_data),
    .in1_vld      (in1_vld),
    .in1_rdy      (in1_rdy),
    .in1_addr     (in1_addr),
    .in1_data     (in1_data),
    .wr0_vld      (wr0_vld),
    .wr0_conflict (wr0_conflict),
    .waddr0       (waddr0),
    .wdata0       (wdata0),
    .wr1_vld      (wr1_vld),
    .wr1_conflict (wr1_conflict),
    .waddr1       (waddr1),
    .wdata1       (wdata1),
`ifdef VRF_WB_PERF_EN
    .conflict_cnt (conflict_cnt),
`endif
    .empty        (empty)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic v0, input logic [4:0] a0, input logic [63:0] d0,
                      input logic v1, input logic [4:0] a1, input logic [63:0] d1);
    in0_vld = v0; in0_addr = a0; in0_data = d0;
    in1_vld = v1; in1_addr = a1; in1_data = d1;
    tick();
    in0_vld = 1'b0;
    in1_vld = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in0_vld = 0; in1_vld = 0; in0_addr = 0; in1_addr = 0; in0_data = 0; in1_data = 0;
    wr0_conflict = 0; wr1_conflict = 0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_wr0_vld", wr0_vld, 0);
    check("rst_wr1_vld", wr1_vld, 0);
    check("rst_in0_rdy", in0_rdy, 1);
    check("rst_in1_rdy", in1_rdy, 1);
    check("rst_empty",   empty,   1);
`ifdef VRF_WB_PERF_EN
    check("rst_conf_cnt", conflict_cnt, 0);
`endif

    // Single result: no bypass, written the next cycle, then retired.
    in0_vld = 1; in0_addr = 3; in0_data = 64'hA5;
    #1 check("t1_no_bypass", wr0_vld, 0);
    push(1, 3, 64'hA5, 0, 0, 0);
    check("t1_wr0_vld", wr0_vld, 1);
    check("t1_waddr0",  waddr0, 3);
    check("t1_wdata0",  wdata0, 64'hA5);
    check("t1_wr1_cnt1", wr1_vld, 0);
    check("t1_not_empty", empty, 0);
    tick();
    check("t1_empty", empty, 1);
    check("t1_wr0_idle", wr0_vld, 0);

    // Pair with distinct addresses retires in one cycle.
    push(1, 4, 64'h44, 1, 9, 64'h99);
    check("t2_waddr0", waddr0, 4);
    check("t2_wr1_vld", wr1_vld, 1);
    check("t2_waddr1", waddr1, 9);
    check("t2_wdata1", wdata1, 64'h99);
    tick();
    check("t2_empty", empty, 1);

    // Head conflicts, slot 1 granted: slot 1 marked done, head retries.
    push(1, 4, 64'h44, 1, 9, 64'h99);
    wr0_conflict = 1;
    tick();
    wr0_conflict = 0;
    #1;
    check("t3_wr0_vld", wr0_vld, 1);
    check("t3_waddr0",  waddr0, 4);
    check("t3_wr1_done", wr1_vld, 0);
    check("t3_not_empty", empty, 0);
    tick();
    check("t3_pop2_empty", empty, 1);
`ifdef VRF_WB_PERF_EN
    check("t3_conf_cnt", conflict_cnt, 1);
`endif

    // Same destination: second write waits for the head.
    push(1, 7, 64'h71, 1, 7, 64'h72);
    check("t4_wdata0_a", wdata0, 64'h71);
    check("t4_wr1_waw", wr1_vld, 0);
    tick();
    check("t4_wr0_vld_b", wr0_vld, 1);
    check("t4_wdata0_b", wdata0, 64'h72);
    check("t4_wr1_cnt1", wr1_vld, 0);
    tick();
    check("t4_empty", empty, 1);

    // Slot 0 granted, slot 1 conflicts: pop one.
    push(1, 21, 64'h21, 1, 22, 64'h22);
    wr1_conflict = 1;
    tick();
    wr1_conflict = 0;
    #1;
    check("t5_wr0_vld", wr0_vld, 1);
    check("t5_waddr0", waddr0, 22);
    check("t5_wdata0", wdata0, 64'h22);
    check("t5_wr1_cnt1", wr1_vld, 0);
    tick();
    check("t5_empty", empty, 1);

    // Conflicts while nothing is requested are ignored.
    wr0_conflict = 1; wr1_conflict = 1;
    tick();
    check("t5_idle_empty", empty, 1);
`ifdef VRF_WB_PERF_EN
    check("t5_idle_conf_cnt", conflict_cnt, 2);
`endif

    // Fill to 7 with both ports blocked, drop an input when full, then hold.
    rst = 1; tick(); rst = 0;
    push(1, 10, 64'h10, 1, 11, 64'h11);
    push(1, 12, 64'h12, 1, 13, 64'h13);
    push(1, 14, 64'h14, 1, 15, 64'h15);
    check("t6_rdy_at6", in0_rdy, 1);
    push(1, 16, 64'h16, 0, 0, 0);
    check("t6_in0_rdy_full", in0_rdy, 0);
    check("t6_in1_rdy_full", in1_rdy, 0);
`ifdef VRF_WB_PERF_EN
    check("t6_conf_cnt_fill", conflict_cnt, 6);
`endif
    push(1, 20, 64'h20, 0, 0, 0);
`ifdef VRF_WB_PERF_EN
    check("t6_conf_cnt_drop", conflict_cnt, 8);
`endif
    for (int i = 0; i < 5; i++) begin
      check("t6_hold_waddr0", waddr0, 10);
      check("t6_hold_waddr1", waddr1, 11);
      check("t6_hold_wr1_vld", wr1_vld, 1);
      tick();
    end
    check("t6_hold_rdy", in0_rdy, 0);
`ifdef VRF_WB_PERF_EN
    check("t6_conf_cnt_hold", conflict_cnt, 18);
`endif
    wr0_conflict = 0; wr1_conflict = 0;
    tick();
    check("t6_drain_rdy", in0_rdy, 1);
    check("t6_drain_a", waddr0, 12);
    tick();
    check("t6_drain_b", waddr0, 14);
    tick();
    check("t6_drain_c", waddr0, 16);
    check("t6_drain_c_wr1", wr1_vld, 0);
    tick();
    check("t6_drop_empty", empty, 1);

    // Reset with five pending entries.
    wr0_conflict = 1; wr1_conflict = 1;
    push(1, 1, 64'h1, 1, 2, 64'h2);
    push(1, 3, 64'h3, 1, 4, 64'h4);
    push(1, 5, 64'h5, 0, 0, 0);
    check("t7_pending", empty, 0);
    rst = 1;
    #1;
    check("t7_rst_wr0_quiet", wr0_vld, 0);
    check("t7_rst_wr1_quiet", wr1_vld, 0);
    tick();
    rst = 0; wr0_conflict = 0; wr1_conflict = 0;
    #1;
    check("t7_empty", empty, 1);
    check("t7_wr0_vld", wr0_vld, 0);
    check("t7_wr1_vld", wr1_vld, 0);
    check("t7_rdy", in0_rdy, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vrf_wb_queue.md
Name: vrf_wb_queue

Overview:
- Write-back buffer between the vector functional units and the vector register file write ports.
- Accepts up to two FU results per cycle into an in-order circular queue.
- Presents the oldest two pending results on the register file's wr0/wr1 ports.
- Holds and retries any result the register file reports as a bank conflict, so FUs never stall on write arbitration.

Parameters:
- DEPTH, 8, queue entries; power of two, at least 4.
- ADDR_WIDTH, VREG_ADDR_WIDTH, vector register address width.
- DATA_WIDTH, VFULEN, write data width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in0_vld  in  1  FU result 0 valid.
- in0_rdy  out  1  queue can accept result 0.
- in0_addr  in  ADDR_WIDTH  result 0 destination register.
- in0_data  in  DATA_WIDTH  result 0 data.
- in1_vld  in  1  FU result 1 valid.
- in1_rdy  out  1  queue can accept result 1.
- in1_addr  in  ADDR_WIDTH  result 1 destination register.
- in1_data  in  DATA_WIDTH  result 1 data.
- wr0_vld  out  1  write port 0 request.
- wr0_conflict  in  1  port 0 not granted this cycle (combinational from register file).
- waddr0  out  ADDR_WIDTH  port 0 address.
- wdata0  out  DATA_WIDTH  port 0 data.
- wr1_vld  out  1  write port 1 request.
- wr1_conflict  in  1  port 1 not granted this cycle.
- waddr1  out  ADDR_WIDTH  port 1 address.
- wdata1  out  DATA_WIDTH  port 1 data.
- empty  out  1  no pending entries.

Behaviour:
- Storage:
  - Circular buffer of {addr, data, done} entries.
  - Head/tail pointers are log2(DEPTH) bits, with a registered count of log2(DEPTH)+1 bits.
- Reset: all pointers, count and done bits = 0; wr0_vld = wr1_vld = 0; in0_rdy = in1_rdy = 1; empty = 1. Data contents are don't-care.
- Reset mid-operation drops all pending entries; no write is issued in the reset cycle.
- Ready: in0_rdy = in1_rdy = (count <= DEPTH-2), from the registered count only. Same-cycle dequeue never raises ready.
- Enqueue:
  - A port is accepted when vld & rdy.
  - When both are accepted, in0 is written to tail and in1 to tail+1.
  - If only in1 is valid, it is written to tail.
  - tail advances by the number accepted.
- Latency: an entry enqueued in cycle t may drive the wr ports in cycle t+1 at the earliest; there is no bypass.
- Slot 0 = head:
  - wr0_vld = (count >= 1) & ~done[head].
  - waddr0/wdata0 come from the head entry.
- Slot 1 = head+1:
  - wr1_vld = (count >= 2) & ~done[head+1] & (addr[head+1] != addr[head]).
  - The address check prevents reordering of writes to the same register (WAW).
- Grant: slot k is granted when wrk_vld & ~wrk_conflict.
- Retire rules:
  - Slot 0 granted or already done: it pops.
  - Slot 1 granted or already done, and slot 0 popping: both pop (pop 2).
  - Slot 1 granted while slot 0 conflicts: set done[head+1]; head does not move.
  - Slot 0 conflicts and slot 1 is not granted: no change.
- done bits are cleared when their entry pops.
- Simultaneous enqueue and dequeue: count_next = count + accepted − popped. Pointers wrap modulo DEPTH.
- Boundaries:
  - Full (count > DEPTH-2): both rdy = 0 and valid inputs are ignored.
  - Empty: both wr_vld = 0 and empty = 1.
  - count = 1: slot 1 is never driven.
- A conflict input asserted while its wr_vld is 0 is ignored.

Optional Feature:
- Macro: VRF_WB_PERF_EN.
- With it:
  - Extra output port conflict_cnt (32 bits).
  - Increments by the number of slots with wrk_vld & wrk_conflict in a cycle (0, 1 or 2).
  - Saturates at 2^32-1 and resets to 0.
- Without it: no port, no counter logic, and behaviour is otherwise identical.

Decomposition:
- Shared package rrv64_core_vec_param_pkg gains:
  - vrf_wb_entry_t {addr, data, done};
  - VRF_WB_DEPTH = 8.
- One natural sub-module: vrf_wb_retire_ctrl, which is combinational and computes wr_vld, pop count and done-set from head entries and conflicts.
- Storage and pointers stay in the top.

Test Plan:
- Reset, then in0 addr 3 data 0xA5 → wr0_vld=1 with waddr0=3 the next cycle; no conflict → empty=1 the cycle after.
- Enqueue addr 4 and addr 9 together with no conflicts → both written in one cycle; count 2→0.
- Head addr 4, next addr 9; wr0_conflict=1, wr1_conflict=0 → done set on addr 9; next cycle wr1_vld=0, wr0_vld=1 with waddr0=4; grant → pop 2.
- Head and next both addr 7 → wr1_vld=0 until head retires; the second write to 7 issues the following cycle.
- Fill to count 7 → rdy=0 and an in0 pulse is dropped; then hold conflicts on both ports for 5 cycles → no pops, and conflict_cnt=10 with VRF_WB_PERF_EN defined.
- Assert rst with 5 entries pending → next cycle count=0, empty=1, wr0_vld=wr1_vld=0.
